imem_fetch_unit: RTL and testbench



---
 rtl/imem_fetch_unit.sv | 93 +++++++++
 tb/tb_imem_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit.sv
// Instruction-fetch slice: next-PC select (PC+PC_INC or branch target) and a
// word-organised instruction memory with a combinational read port and a
// synchronous program-load port. The PC register and IF/ID latch live in the
// stage wrapper.
//
// Interface timing: there is no valid/ready handshake. The block is always
// ready; a load is accepted on every rising clk edge where load_en is high,
// and read data is valid in the same cycle that pc is presented.
module imem_fetch_unit #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int PC_INC = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_pc,
   output logic [ADDR_W-1:0] next_pc,
   output logic [DATA_W-1:0] instr,
   output logic              misaligned,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_err
);

   // Word index width derived from the byte address; the memory itself only
   // needs enough bits to cover DEPTH words.
   localparam int IDX_W  = ADDR_W - 2;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  wr_idx;
   logic              rd_in_range;
   logic              wr_in_range;
   logic              wr_aligned;
   logic              wr_ok;

   assign rd_idx      = pc[ADDR_W-1:2];
   assign wr_idx      = load_addr[ADDR_W-1:2];
   assign rd_in_range = ({1'b0, rd_idx} < DEPTH_L);
   assign wr_in_range = ({1'b0, wr_idx} < DEPTH_L);
   assign wr_aligned  = (load_addr[1:0] == 2'b00);
   assign wr_ok       = load_en && wr_aligned && wr_in_range;

   // Next-PC select; wraps modulo 2^ADDR_W and ignores reset.
   always_comb begin
      next_pc = pc + ADDR_W'(PC_INC);
      if (branch_taken) begin
         next_pc = branch_pc;
      end
   end

   // Alignment flag is purely a decode of the low PC bits.
   always_comb begin
      misaligned = |pc[1:0];
   end

   // Zero-latency read; out-of-range words and reset both read as NOP (0).
   // The low PC bits are dropped, so a misaligned PC returns the truncated word.
   always_comb begin
      instr = '0;
      if (!reset && rd_in_range) begin
         instr = mem[rd_idx[MEM_AW-1:0]];
      end
   end

   // Program-load port; reset wipes every word, no read bypass on writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[wr_idx[MEM_AW-1:0]] <= load_data;
      end
   end

   // Load error flag reflects the most recent load attempt only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_err <= 1'b0;
      end else if (load_en) begin
         load_err <= !(wr_aligned && wr_in_range);
      end
   end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit, built with a 128-word memory so that the upper
// half of the 10-bit address space is out of range.
module tb_imem_fetch_unit;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 128;
   localparam int PC_INC = 4;
   localparam int SPACE  = 1 << ADDR_W;

   logic              clk;
   logic              reset;
   logic [ADDR_W-1:0] pc;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_pc;
   logic [ADDR_W-1:0] next_pc;
   logic [DATA_W-1:0] instr;
   logic              misaligned;
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [DATA_W-1:0] load_data;
   logic              load_err;

   imem_fetch_unit #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PC_INC(PC_INC)
   ) dut (
      .clk(clk), .reset(reset), .pc(pc), .branch_taken(branch_taken),
      .branch_pc(branch_pc), .next_pc(next_pc), .instr(instr),
      .misaligned(misaligned), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .load_err(load_err)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [DATA_W-1:0] model_mem [DEPTH];
   logic              model_err;
   logic [DATA_W-1:0] exp_q [$];
   int n_cmp;
   int n_fail;

   function automatic logic [DATA_W-1:0] ref_instr(input int addr);
      int w;
      w = addr / 4;
      if (w < DEPTH) return model_mem[w];
      return '0;
   endfunction

   function automatic int ref_next(input int p, input bit bt, input int bp);
      if (bt) return bp;
      return (p + PC_INC) % SPACE;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_err = 1'b0;
   endtask

   // Applies one load attempt to the model using the byte-address rules.
   task automatic model_load(input int addr, input logic [DATA_W-1:0] data);
      if ((addr % 4 == 0) && (addr / 4 < DEPTH)) begin
         model_mem[addr / 4] = data;
         model_err = 1'b0;
      end else begin
         model_err = 1'b1;
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_pc(input int p);
      pc = ADDR_W'(p);
      #1;
   endtask

   task automatic do_load(input int addr, input logic [DATA_W-1:0] data);
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = ADDR_W'(addr);
      load_data = data;
      @(posedge clk);
      #1;
      load_en = 1'b0;
      model_load(addr, data);
   endtask

   typedef struct {
      logic [ADDR_W-1:0] pc;
      logic              bt;
      logic [ADDR_W-1:0] bpc;
      logic [ADDR_W-1:0] exp_next;
      logic              exp_mis;
   } mux_vec_t;

   mux_vec_t vecs [8];

   initial begin
      int p, bp, a, kind;
      bit bt, le;
      logic [DATA_W-1:0] d;

      vecs[0] = '{pc: 10'h008, bt: 1'b0, bpc: 10'h000, exp_next: 10'h00C, exp_mis: 1'b0};
      vecs[1] = '{pc: 10'h008, bt: 1'b1, bpc: 10'h040, exp_next: 10'h040, exp_mis: 1'b0};
      vecs[2] = '{pc: 10'h3FC, bt: 1'b0, bpc: 10'h000, exp_next: 10'h000, exp_mis: 1'b0};
      vecs[3] = '{pc: 10'h006, bt: 1'b0, bpc: 10'h100, exp_next: 10'h00A, exp_mis: 1'b1};
      vecs[4] = '{pc: 10'h3FF, bt: 1'b0, bpc: 10'h000, exp_next: 10'h003, exp_mis: 1'b1};
      vecs[5] = '{pc: 10'h3FD, bt: 1'b1, bpc: 10'h3FC, exp_next: 10'h3FC, exp_mis: 1'b1};
      vecs[6] = '{pc: 10'h000, bt: 1'b0, bpc: 10'h2A8, exp_next: 10'h004, exp_mis: 1'b0};
      vecs[7] = '{pc: 10'h1F0, bt: 1'b1, bpc: 10'h001, exp_next: 10'h001, exp_mis: 1'b0};

      n_cmp = 0;
      n_fail = 0;
      reset = 1'b1;
      pc = '0;
      branch_taken = 1'b0;
      branch_pc = '0;
      load_en = 1'b0;
      load_addr = '0;
      load_data = '0;
      model_clear();

      // Reset state: reads zero, no load error, mux still live.
      repeat (2) @(posedge clk);
      #1;
      set_pc(0);
      check("rst_instr", instr, 32'h0);
      check("rst_load_err", 32'(load_err), 32'h0);
      set_pc(10'h008);
      check("rst_next_pc", 32'(next_pc), 32'h00C);

      // Release at a negedge; the load at the very next edge must land.
      @(negedge clk);
      reset = 1'b0;
      set_pc(10'h010);
      check("post_rst_instr", instr, 32'h0);
      do_load(10'h000, 32'h8C220004);
      do_load(10'h004, 32'h00430820);
      set_pc(0);
      check("fetch0", instr, 32'h8C220004);
      check("fetch0_mis", 32'(misaligned), 32'h0);
      set_pc(4);
      check("fetch4", instr, 32'h00430820);
      check("fetch4_mis", 32'(misaligned), 32'h0);

      // Next-PC mux and alignment decode table.
      for (int i = 0; i < 8; i++) begin
         branch_taken = vecs[i].bt;
         branch_pc    = vecs[i].bpc;
         set_pc(int'(vecs[i].pc));
         check($sformatf("vec%0d_next_pc", i), 32'(next_pc), 32'(vecs[i].exp_next));
         check($sformatf("vec%0d_mis", i), 32'(misaligned), 32'(vecs[i].exp_mis));
         check($sformatf("vec%0d_instr", i), instr, ref_instr(int'(vecs[i].pc)));
      end
      branch_taken = 1'b0;

      // Misaligned read returns the truncated word; misaligned load is refused.
      set_pc(10'h006);
      check("mis_read", instr, 32'h00430820);
      do_load(10'h002, 32'hDEADBEEF);
      check("mis_load_err", 32'(load_err), 32'h1);
      set_pc(0);
      check("mis_load_nowrite", instr, 32'h8C220004);
      @(negedge clk);
      set_pc(0);
      check("err_holds", 32'(load_err), 32'h1);
      do_load(10'h008, 32'h01234567);
      check("valid_load_err", 32'(load_err), 32'h0);
      set_pc(10'h008);
      check("load8", instr, 32'h01234567);

      // Range: index 128 and above read zero and cannot be written.
      set_pc(10'h200);
      check("range_read", instr, 32'h0);
      do_load(10'h200, 32'hCAFEF00D);
      check("range_load_err", 32'(load_err), 32'h1);
      set_pc(10'h200);
      check("range_after", instr, 32'h0);
      set_pc(10'h000);
      check("range_alias", instr, 32'h8C220004);

      // Read-during-write: old value before the edge, new value after.
      do_load(10'h010, 32'h11111111);
      @(negedge clk);
      set_pc(10'h010);
      load_en   = 1'b1;
      load_addr = 10'h010;
      load_data = 32'h22222222;
      #1;
      check("rdw_before", instr, 32'h11111111);
      @(posedge clk);
      #1;
      load_en = 1'b0;
      model_load(10'h010, 32'h22222222);
      check("rdw_after", instr, 32'h22222222);

      // Randomized loads and fetches against the model.
      for (int it = 0; it < 400; it++) begin
         @(negedge clk);
         p    = int'($urandom_range(0, SPACE - 1));
         bt   = 1'($urandom_range(0, 1));
         bp   = int'($urandom_range(0, SPACE - 1));
         le   = ($urandom_range(0, 3) != 0);
         kind = int'($urandom_range(0, 9));
         if (kind < 6)      a = int'($urandom_range(0, DEPTH - 1)) * 4;
         else if (kind < 8) a = int'($urandom_range(0, DEPTH - 1)) * 4 + int'($urandom_range(1, 3));
         else               a = int'($urandom_range(0, SPACE - 1));
         if ($urandom_range(0, 2) == 0) p = a;
         d = $urandom;
         branch_taken = bt;
         branch_pc    = ADDR_W'(bp);
         load_en      = le;
         load_addr    = ADDR_W'(a);
         load_data    = d;
         set_pc(p);
         check("rnd_next_pc", 32'(next_pc), 32'(ref_next(p, bt, bp)));
         check("rnd_mis", 32'(misaligned), 32'((p % 4) != 0));
         check("rnd_instr_pre", instr, ref_instr(p));
         @(posedge clk);
         #1;
         load_en = 1'b0;
         if (le) model_load(a, d);
         exp_q.push_back(ref_instr(p));
         check("rnd_load_err", 32'(load_err), 32'(model_err));
         check("rnd_instr_post", instr, exp_q.pop_front());
      end

      // Reset mid-run: instr drops at once, every word reads zero afterwards.
      set_pc(10'h010);
      #2;
      reset = 1'b1;
      #1;
      model_clear();
      check("midrst_instr", instr, 32'h0);
      check("midrst_load_err", 32'(load_err), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int w = 0; w < DEPTH; w++) begin
         set_pc(w * 4);
         check("midrst_word", instr, ref_instr(w * 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
